// File: rtl/fp_mult_pkg.sv
// Shared constants for the pipelined FP multiplier: flag bit positions, operand
// class bits and special-value encodings parameterised by exponent/mantissa width.
package fp_mult_pkg;

   localparam int FLAGS_W      = 5;
   localparam int FLAG_INVALID = 4;
   localparam int FLAG_INF     = 3;
   localparam int FLAG_OVF     = 2;
   localparam int FLAG_UNF     = 1;
   localparam int FLAG_INEXACT = 0;

   // Operand-pair class carried down the pipe; round stage resolves nan > inf > zero.
   localparam int CLS_W    = 4;
   localparam int CLS_NAN  = 3;
   localparam int CLS_INV  = 2;
   localparam int CLS_INF  = 1;
   localparam int CLS_ZERO = 0;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
      return ((64'd1 << exp_w) - 64'd1) << man_w;
   endfunction

   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
   endfunction

   function automatic logic [63:0] fp_max_finite(input int exp_w, input int man_w);
      return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
   endfunction

endpackage

// File: rtl/fp_mult_round.sv
// Final stage of fp_mult_pipe: rounding, renormalisation, range check and pack.
// FP_MULT_PIPE_RNE_EN selects round-to-nearest-even (overflow -> inf); otherwise truncate.
module fp_mult_round
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                 sign,
   input  logic [EXP_W+1:0]     exp_in,
   input  logic [2*MAN_W:0]     frac,
   input  logic [CLS_W-1:0]     cls,
   output logic [EXP_W+MAN_W:0] result,
   output logic [FLAGS_W-1:0]   flags
);

   localparam int DW = 1 + EXP_W + MAN_W;
   localparam logic [DW-1:0]  QNAN     = DW'(fp_qnan(EXP_W, MAN_W));
   localparam logic [DW-1:0]  INF      = DW'(fp_inf(EXP_W, MAN_W));
   localparam logic [EXP_W:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};
`ifdef FP_MULT_PIPE_RNE_EN
   localparam bit             RNE      = 1'b1;
   localparam logic [DW-1:0]  OVF_VAL  = INF;
`else
   localparam bit             RNE      = 1'b0;
   localparam logic [DW-1:0]  OVF_VAL  = DW'(fp_max_finite(EXP_W, MAN_W));
`endif

   logic [MAN_W-1:0] man;
   logic             guard, sticky, round_up;
   logic [MAN_W:0]   man_r;
   logic [EXP_W+1:0] exp_r;
   logic             ovf, unf;

   always_comb begin
      // frac excludes the implicit leading one: kept mantissa, then guard, then sticky bits.
      man      = frac[2*MAN_W:MAN_W+1];
      guard    = frac[MAN_W];
      sticky   = |frac[MAN_W-1:0];
      round_up = RNE & guard & (sticky | man[0]);
      man_r    = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
      exp_r    = exp_in + {{(EXP_W+1){1'b0}}, man_r[MAN_W]};
      ovf      = ~exp_r[EXP_W+1] & (exp_r[EXP_W:0] >= EXP_ONES);
      unf      = exp_r[EXP_W+1] | (exp_r == '0);

      result = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      flags  = '0;
      flags[FLAG_INEXACT] = guard | sticky;
      if (cls[CLS_NAN]) begin
         result = QNAN;
         flags  = '0;
         flags[FLAG_INVALID] = cls[CLS_INV];
      end else if (cls[CLS_INF]) begin
         result = {sign, INF[DW-2:0]};
         flags  = '0;
         flags[FLAG_INF] = 1'b1;
      end else if (cls[CLS_ZERO]) begin
         result = {sign, {(DW-1){1'b0}}};
         flags  = '0;
      end else if (ovf) begin
         result = {sign, OVF_VAL[DW-2:0]};
         flags  = '0;
         flags[FLAG_OVF]     = 1'b1;
         flags[FLAG_INEXACT] = 1'b1;
         flags[FLAG_INF]     = RNE;
      end else if (unf) begin
         result = {sign, {(DW-1){1'b0}}};
         flags  = '0;
         flags[FLAG_UNF]     = 1'b1;
         flags[FLAG_INEXACT] = 1'b1;
      end
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// 3-stage IEEE-format multiplier with valid/ready handshake and whole-pipe stall.
// Rounding mode set by FP_MULT_PIPE_RNE_EN (defined: RNE, undefined: truncate).
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic [FLAGS_W-1:0]   flags
);

   localparam int DW = 1 + EXP_W + MAN_W;
   localparam int SW = 2*MAN_W + 2;
   localparam int XW = EXP_W + 2;
   localparam logic [XW-1:0] BIAS = XW'(fp_bias(EXP_W));

   logic             advance;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_man, b_man;
   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inv;

   logic             s1_vld_d, s1_vld_q, s1_sign_d, s1_sign_q;
   logic [XW-1:0]    s1_exp_d, s1_exp_q;
   logic [SW-1:0]    s1_sig_d, s1_sig_q;
   logic [CLS_W-1:0] s1_cls_d, s1_cls_q;

   logic             s2_vld_d, s2_vld_q, s2_sign_d, s2_sign_q;
   logic [XW-1:0]    s2_exp_d, s2_exp_q;
   logic [SW-2:0]    s2_frac_d, s2_frac_q;
   logic [CLS_W-1:0] s2_cls_d, s2_cls_q;

   logic               out_valid_d, out_valid_q;
   logic [DW-1:0]      result_d, result_q, rnd_result;
   logic [FLAGS_W-1:0] flags_d, flags_q, rnd_flags;

   assign advance   = ~out_valid_q | out_ready;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

   always_comb begin
      a_exp  = a[DW-2:MAN_W];
      b_exp  = b[DW-2:MAN_W];
      a_man  = a[MAN_W-1:0];
      b_man  = b[MAN_W-1:0];
      a_nan  = (&a_exp) & (|a_man);
      b_nan  = (&b_exp) & (|b_man);
      a_inf  = (&a_exp) & ~(|a_man);
      b_inf  = (&b_exp) & ~(|b_man);
      // Subnormals are classed as zero.
      a_zero = ~(|a_exp);
      b_zero = ~(|b_exp);
      inv    = ~(a_nan | b_nan) & ((a_inf & b_zero) | (a_zero & b_inf));
   end

   // S1: classify, unbiased exponent sum, full significand product.
   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_sign_d = s1_sign_q;
      s1_exp_d  = s1_exp_q;
      s1_sig_d  = s1_sig_q;
      s1_cls_d  = s1_cls_q;
      if (advance) begin
         s1_vld_d  = in_valid;
         s1_sign_d = a[DW-1] ^ b[DW-1];
         s1_exp_d  = XW'(a_exp) + XW'(b_exp) - BIAS;
         s1_sig_d  = SW'({1'b1, a_man}) * SW'({1'b1, b_man});
         s1_cls_d  = '0;
         s1_cls_d[CLS_NAN]  = a_nan | b_nan | inv;
         s1_cls_d[CLS_INV]  = inv;
         s1_cls_d[CLS_INF]  = a_inf | b_inf;
         s1_cls_d[CLS_ZERO] = a_zero | b_zero;
      end
   end

   // S2: normalise so the leading one sits just above frac; it is implicit from here on.
   always_comb begin
      s2_vld_d  = s2_vld_q;
      s2_sign_d = s2_sign_q;
      s2_exp_d  = s2_exp_q;
      s2_frac_d = s2_frac_q;
      s2_cls_d  = s2_cls_q;
      if (advance) begin
         s2_vld_d  = s1_vld_q;
         s2_sign_d = s1_sign_q;
         s2_cls_d  = s1_cls_q;
         if (s1_sig_q[SW-1]) begin
            s2_exp_d  = s1_exp_q + XW'(1);
            s2_frac_d = s1_sig_q[SW-2:0];
         end else begin
            s2_exp_d  = s1_exp_q;
            s2_frac_d = {s1_sig_q[SW-3:0], 1'b0};
         end
      end
   end

   fp_mult_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
      .sign   (s2_sign_q),
      .exp_in (s2_exp_q),
      .frac   (s2_frac_q),
      .cls    (s2_cls_q),
      .result (rnd_result),
      .flags  (rnd_flags)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      if (advance) begin
         out_valid_d = s2_vld_q;
         result_d    = rnd_result;
         flags_d     = rnd_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0; s1_sign_q <= 1'b0; s1_exp_q <= '0; s1_sig_q <= '0; s1_cls_q <= '0;
         s2_vld_q <= 1'b0; s2_sign_q <= 1'b0; s2_exp_q <= '0; s2_frac_q <= '0; s2_cls_q <= '0;
         out_valid_q <= 1'b0; result_q <= '0; flags_q <= '0;
      end else begin
         s1_vld_q <= s1_vld_d; s1_sign_q <= s1_sign_d; s1_exp_q <= s1_exp_d;
         s1_sig_q <= s1_sig_d; s1_cls_q <= s1_cls_d;
         s2_vld_q <= s2_vld_d; s2_sign_q <= s2_sign_d; s2_exp_q <= s2_exp_d;
         s2_frac_q <= s2_frac_d; s2_cls_q <= s2_cls_d;
         out_valid_q <= out_valid_d; result_q <= result_d; flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: fp16 vector table, backpressure/reset sequences, random stream
// against an integer-arithmetic reference, plus a bfloat16 instance.
module tb_fp_mult_pipe;

`ifdef FP_MULT_PIPE_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   logic        clk, rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, result;
   logic [4:0]  flags;
   logic        in_valid2, in_ready2, out_valid2, out_ready2;
   logic [15:0] a2, b2, result2;
   logic [4:0]  flags2;

   fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags));

   fp_mult_pipe #(.EXP_W(8), .MAN_W(7)) dut_bf (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
      .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .flags(flags2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a, b, r_rne;
      logic [4:0]  f_rne;
      logic [15:0] r_tz;
      logic [4:0]  f_tz;
   } vec_t;

   int          n_chk, n_fail, n_pop, cyc;
   logic [20:0] sbq[$];
   int          pop_cycs[$];
   logic [15:0] last_res;
   logic [4:0]  last_fl;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Reference: exact integer product, then round with div/mod on the discarded part.
   function automatic logic [20:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                           input int ew, input int mw, input bit rne);
      int emax, bias, ex, ey, mx, my, e, be, n, sh, sgn, r;
      bit xn, yn, xi, yi, xz, yz, inex;
      longint p, q, rem, half;
      logic [4:0] f;
      emax = (1 << ew) - 1;
      bias = (1 << (ew - 1)) - 1;
      ex = (int'(x) >> mw) & emax;  mx = int'(x) & ((1 << mw) - 1);
      ey = (int'(y) >> mw) & emax;  my = int'(y) & ((1 << mw) - 1);
      sgn = (x[15] ^ y[15]) ? 32'h8000 : 0;
      xn = (ex == emax) && (mx != 0);  yn = (ey == emax) && (my != 0);
      xi = (ex == emax) && (mx == 0);  yi = (ey == emax) && (my == 0);
      xz = (ex == 0);                  yz = (ey == 0);
      f = 5'b0;
      r = 0;
      if (xn || yn) r = (emax << mw) | (1 << (mw - 1));
      else if ((xi && yz) || (yi && xz)) begin
         r = (emax << mw) | (1 << (mw - 1));
         f = 5'b10000;
      end else if (xi || yi) begin
         r = sgn | (emax << mw);
         f = 5'b01000;
      end else if (xz || yz) r = sgn;
      else begin
         p = longint'((1 << mw) | mx) * longint'((1 << mw) | my);
         n = 0;
         for (int i = 0; i < 48; i++) if (p[i]) n = i;
         e    = (ex - bias) + (ey - bias) + (n - 2*mw);
         sh   = n - mw;
         q    = p >> sh;
         rem  = p - (q << sh);
         half = longint'(1) << (sh - 1);
         inex = (rem != 0);
         if (rne && (rem > half || (rem == half && q[0]))) q++;
         if (q == (longint'(1) << (mw + 1))) begin
            q = q >> 1;
            e++;
         end
         be = e + bias;
         if (be >= emax) begin
            f = rne ? 5'b01101 : 5'b00101;
            r = rne ? (sgn | (emax << mw)) : (sgn | ((emax - 1) << mw) | ((1 << mw) - 1));
         end else if (be <= 0) begin
            f = 5'b00011;
            r = sgn;
         end else begin
            f = {4'b0, inex};
            r = sgn | (be << mw) | int'(q - (longint'(1) << mw));
         end
      end
      return {f, r[15:0]};
   endfunction

   // One clock of the fp16 DUT: drive, record handshakes, check deliveries, advance.
   task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ordy, output bit acc);
      logic [20:0] e;
      in_valid = iv; a = ia; b = ib; out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: got result %0h with nothing outstanding", result);
         end else begin
            e = sbq.pop_front();
            chk("sb_result", {16'b0, result}, {16'b0, e[15:0]});
            chk("sb_flags", {27'b0, flags}, {27'b0, e[20:16]});
            last_res = result;
            last_fl  = flags;
            pop_cycs.push_back(cyc);
            n_pop++;
         end
      end
      if (acc) sbq.push_back(ref_mul(ia, ib, 5, 10, RNE));
      @(negedge clk);
      cyc++;
   endtask

   function automatic logic [15:0] rnd_op();
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) v[14:10] = 5'($urandom_range(8, 22));
      return v;
   endfunction

   vec_t        tab[12];
   vec_t        bt[3];
   bit          acc;
   int          lat, np0, nacc, k;
   logic [15:0] pa, pb, held;
   logic        pv;
   logic [15:0] opa[5], opb[5];

   initial begin
      n_chk = 0; n_fail = 0; n_pop = 0; cyc = 0;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      in_valid2 = 1'b0; a2 = '0; b2 = '0; out_ready2 = 1'b1;

      tab[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, 5'h00, 16'h3C00, 5'h00};
      tab[1]  = '{16'h4000, 16'h4200, 16'h4600, 5'h00, 16'h4600, 5'h00};
      tab[2]  = '{16'h3C01, 16'h3E00, 16'h3E02, 5'h01, 16'h3E01, 5'h01};
      tab[3]  = '{16'h3C01, 16'h3C01, 16'h3C02, 5'h01, 16'h3C02, 5'h01};
      tab[4]  = '{16'h7C00, 16'h0000, 16'h7E00, 5'h10, 16'h7E00, 5'h10};
      tab[5]  = '{16'h7C00, 16'hC000, 16'hFC00, 5'h08, 16'hFC00, 5'h08};
      tab[6]  = '{16'h7C01, 16'h3C00, 16'h7E00, 5'h00, 16'h7E00, 5'h00};
      tab[7]  = '{16'h0001, 16'h3C00, 16'h0000, 5'h00, 16'h0000, 5'h00};
      tab[8]  = '{16'h7BFF, 16'h4000, 16'h7C00, 5'h0D, 16'h7BFF, 5'h05};
      tab[9]  = '{16'h0400, 16'h0400, 16'h0000, 5'h03, 16'h0000, 5'h03};
      tab[10] = '{16'hC000, 16'h3C00, 16'hC000, 5'h00, 16'hC000, 5'h00};
      tab[11] = '{16'h8000, 16'h7C00, 16'h7E00, 5'h10, 16'h7E00, 5'h10};
      bt[0]   = '{16'h3F80, 16'h3F80, 16'h3F80, 5'h00, 16'h3F80, 5'h00};
      bt[1]   = '{16'h4000, 16'hC040, 16'hC0C0, 5'h00, 16'hC0C0, 5'h00};
      bt[2]   = '{16'h7F80, 16'h0000, 16'h7FC0, 5'h10, 16'h7FC0, 5'h10};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_result", {16'b0, result}, 0);
      chk("rst_flags", {27'b0, flags}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 1);

      // bfloat16 instance
      for (int i = 0; i < 3; i++) begin
         chk("bf_in_ready", {31'b0, in_ready2}, 1);
         in_valid2 = 1'b1; a2 = bt[i].a; b2 = bt[i].b;
         @(negedge clk);
         in_valid2 = 1'b0;
         lat = 1;
         while (!out_valid2 && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         chk("bf_latency", lat, 3);
         chk("bf_result", {16'b0, result2}, {16'b0, bt[i].r_rne});
         chk("bf_flags", {27'b0, flags2}, {27'b0, bt[i].f_rne});
         @(negedge clk);
      end

      // fp16 vector table, one op at a time
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, tab[i].a, tab[i].b, 1'b1, acc);
         chk("tab_accept", {31'b0, acc}, 1);
         np0 = n_pop;
         lat = 0;
         while (n_pop == np0 && lat < 10) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);
            lat++;
         end
         chk("tab_latency", lat, 3);
         chk("tab_result", {16'b0, last_res}, {16'b0, RNE ? tab[i].r_rne : tab[i].r_tz});
         chk("tab_flags", {27'b0, last_fl}, {27'b0, RNE ? tab[i].f_rne : tab[i].f_tz});
      end

      // back-to-back issue -> consecutive outputs
      cycle(1'b1, 16'h3C00, 16'h3C00, 1'b1, acc);
      cycle(1'b1, 16'h4000, 16'h4200, 1'b1, acc);
      for (k = 0; k < 10 && sbq.size() > 0; k++) cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);
      chk("b2b_drained", sbq.size(), 0);
      chk("b2b_gap", pop_cycs[pop_cycs.size()-1] - pop_cycs[pop_cycs.size()-2], 1);
      chk("b2b_last", {16'b0, last_res}, 32'h4600);

      // full-throughput stream
      nacc = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, rnd_op(), rnd_op(), 1'b1, acc);
         if (acc) nacc++;
      end
      for (k = 0; k < 10 && sbq.size() > 0; k++) cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);
      chk("tput_accepts", nacc, 20);
      chk("tput_gap", pop_cycs[pop_cycs.size()-1] - pop_cycs[pop_cycs.size()-20], 19);

      // backpressure: 5 ops offered, consumer stalled for 6 cycles
      for (int i = 0; i < 5; i++) begin
         opa[i] = rnd_op();
         opb[i] = rnd_op();
      end
      np0 = n_pop;
      nacc = 0;
      held = '0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) held = result;
         if (i >= 3) begin
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            chk("bp_hold", {16'b0, result}, {16'b0, held});
         end
         cycle(nacc < 5, opa[nacc % 5], opb[nacc % 5], 1'b0, acc);
         if (acc) nacc++;
      end
      chk("bp_held_count", nacc, 3);
      for (k = 0; k < 30 && (nacc < 5 || sbq.size() > 0); k++) begin
         cycle(nacc < 5, opa[nacc % 5], opb[nacc % 5], 1'b1, acc);
         if (acc) nacc++;
      end
      chk("bp_delivered", n_pop - np0, 5);

      // reset during a stall discards everything in flight
      for (int i = 0; i < 3; i++) cycle(1'b1, rnd_op(), rnd_op(), 1'b0, acc);
      cycle(1'b0, 16'h0, 16'h0, 1'b0, acc);
      rst = 1'b1;
      cycle(1'b0, 16'h0, 16'h0, 1'b0, acc);
      rst = 1'b0;
      chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
      chk("mid_rst_result", {16'b0, result}, 0);
      chk("mid_rst_flags", {27'b0, flags}, 0);
      chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
      sbq.delete();
      np0 = n_pop;
      for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);
      chk("mid_rst_nothing_out", n_pop - np0, 0);

      // random traffic with random backpressure
      pv = 1'b0; pa = '0; pb = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pv) begin
            pv = ($urandom_range(0, 9) < 7);
            pa = rnd_op();
            pb = rnd_op();
         end
         cycle(pv, pa, pb, ($urandom_range(0, 9) < 7), acc);
         if (acc) pv = 1'b0;
      end
      for (k = 0; k < 20 && sbq.size() > 0; k++) cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);
      chk("rand_drained", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
